// File: rtl/soc_mem_arbiter.sv
// N-port data-memory arbiter: round-robin grant, programmable wait states, registered ack.
// Define SOC_MEM_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest eligible index wins).
module soc_mem_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        rw,
  input  logic [NUM_PORTS*DW/8-1:0]   wstrobe,
  input  logic [NUM_PORTS*AW-1:0]     addr,
  input  logic [NUM_PORTS*DW-1:0]     wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DW-1:0]               rdata,
  output logic                        mem_en,
  output logic                        mem_rw,
  output logic [DW/8-1:0]             mem_wstrobe,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wdata,
  input  logic [DW-1:0]               mem_rdata
);

  localparam int SW = DW / 8;
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_rw_q, mem_rw_d;
  logic [SW-1:0]          mem_wstrobe_q, mem_wstrobe_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic [DW-1:0]          mem_wdata_q, mem_wdata_d;

  logic [NUM_PORTS-1:0]   eligible;
  logic                   found;
  logic [GW-1:0]          pick;
  logic                   sel_rw;
  logic [SW-1:0]          sel_strb;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_wdata;

  // Arbitration; masking by ack_q keeps the port just served from re-winning on its stale req.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    eligible = req & ~ack_q;
    found    = 1'b0;
    pick     = '0;
`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found && eligible[p]) begin
        found = 1'b1;
        pick  = GW'(p);
      end
    end
`else
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!found && eligible[p] &&
            ((int'(last_grant_q) + k == p) || (int'(last_grant_q) + k == p + NUM_PORTS))) begin
          found = 1'b1;
          pick  = GW'(p);
        end
      end
    end
`endif
  end

  // Constant-index mux of the winning port's request fields.
  always_comb begin
    sel_rw    = 1'b0;
    sel_strb  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick == GW'(p)) begin
        sel_rw    = rw[p];
        sel_strb  = wstrobe[p*SW +: SW];
        sel_addr  = addr[p*AW +: AW];
        sel_wdata = wdata[p*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    ack_d         = '0;
    rdata_d       = rdata_q;
    mem_en_d      = mem_en_q;
    mem_rw_d      = mem_rw_q;
    mem_wstrobe_d = mem_wstrobe_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = pick;
          mem_en_d      = 1'b1;
          mem_rw_d      = sel_rw;
          mem_wstrobe_d = sel_rw ? sel_strb : '0;
          mem_addr_d    = sel_addr;
          mem_wdata_d   = sel_wdata;
          cnt_d         = 4'(WAIT_STATES);
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!mem_rw_q) rdata_d = mem_rdata;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == GW'(p)) ack_d[p] = 1'b1;
          end
          last_grant_d  = grant_q;
          mem_en_d      = 1'b0;
          mem_rw_d      = 1'b0;
          mem_wstrobe_d = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset to last_grant = NUM_PORTS-1 so that port 0 wins the first round.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      grant_q       <= '0;
      last_grant_q  <= GW'(NUM_PORTS - 1);
      ack_q         <= '0;
      rdata_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_wstrobe_q <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      mem_en_q      <= mem_en_d;
      mem_rw_q      <= mem_rw_d;
      mem_wstrobe_q <= mem_wstrobe_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_rw      = mem_rw_q;
  assign mem_wstrobe = mem_wstrobe_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter: a per-cycle vector table on a 4-port zero-wait instance,
// plus hand sequences on 2-port instances with 3, 2 and 5 wait states.
module tb_soc_mem_arbiter;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Instance A: 4 ports, 0 wait states
  logic [3:0]   a_req, a_rw, a_ack, a_mem_strb;
  logic [15:0]  a_strb;
  logic [127:0] a_addr, a_wdata;
  logic [31:0]  a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic         a_mem_en, a_mem_rw;
  assign a_strb      = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  assign a_addr      = {32'h130, 32'h120, 32'h110, 32'h100};
  assign a_wdata     = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  assign a_mem_rdata = mem_model(a_mem_addr);

  soc_mem_arbiter #(.NUM_PORTS(4), .AW(32), .DW(32), .WAIT_STATES(0)) u_a (
    .clk(clk), .nreset(nreset), .req(a_req), .rw(a_rw), .wstrobe(a_strb), .addr(a_addr),
    .wdata(a_wdata), .ack(a_ack), .rdata(a_rdata), .mem_en(a_mem_en), .mem_rw(a_mem_rw),
    .mem_wstrobe(a_mem_strb), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata));

  // Instance B: 2 ports, 3 wait states (strobed write)
  logic [1:0]  b_req, b_rw, b_ack;
  logic [7:0]  b_strb;
  logic [3:0]  b_mem_strb;
  logic [63:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_en, b_mem_rw;
  assign b_strb      = {4'b0011, 4'b1111};
  assign b_addr      = {32'h200, 32'h0};
  assign b_wdata     = {32'h12345678, 32'h0};
  assign b_mem_rdata = mem_model(b_mem_addr);

  soc_mem_arbiter #(.NUM_PORTS(2), .AW(32), .DW(32), .WAIT_STATES(3)) u_b (
    .clk(clk), .nreset(nreset), .req(b_req), .rw(b_rw), .wstrobe(b_strb), .addr(b_addr),
    .wdata(b_wdata), .ack(b_ack), .rdata(b_rdata), .mem_en(b_mem_en), .mem_rw(b_mem_rw),
    .mem_wstrobe(b_mem_strb), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata));

  // Instance C: 2 ports, 2 wait states (inputs change mid-access)
  logic [1:0]  c_req, c_rw, c_ack;
  logic [7:0]  c_strb;
  logic [3:0]  c_mem_strb;
  logic [63:0] c_addr, c_wdata;
  logic [31:0] c_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic        c_mem_en, c_mem_rw;
  assign c_strb      = 8'hFF;
  assign c_wdata     = {32'hCCCC0001, 32'hCCCC0000};
  assign c_mem_rdata = mem_model(c_mem_addr);

  soc_mem_arbiter #(.NUM_PORTS(2), .AW(32), .DW(32), .WAIT_STATES(2)) u_c (
    .clk(clk), .nreset(nreset), .req(c_req), .rw(c_rw), .wstrobe(c_strb), .addr(c_addr),
    .wdata(c_wdata), .ack(c_ack), .rdata(c_rdata), .mem_en(c_mem_en), .mem_rw(c_mem_rw),
    .mem_wstrobe(c_mem_strb), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_rdata(c_mem_rdata));

  // Instance D: 2 ports, 5 wait states (reset mid-access)
  logic [1:0]  d_req, d_rw, d_ack;
  logic [7:0]  d_strb;
  logic [3:0]  d_mem_strb;
  logic [63:0] d_addr, d_wdata;
  logic [31:0] d_rdata, d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic        d_mem_en, d_mem_rw;
  assign d_strb      = 8'hFF;
  assign d_addr      = {32'h400, 32'h300};
  assign d_wdata     = {32'hDDDD0001, 32'hDDDD0000};
  assign d_mem_rdata = mem_model(d_mem_addr);

  soc_mem_arbiter #(.NUM_PORTS(2), .AW(32), .DW(32), .WAIT_STATES(5)) u_d (
    .clk(clk), .nreset(nreset), .req(d_req), .rw(d_rw), .wstrobe(d_strb), .addr(d_addr),
    .wdata(d_wdata), .ack(d_ack), .rdata(d_rdata), .mem_en(d_mem_en), .mem_rw(d_mem_rw),
    .mem_wstrobe(d_mem_strb), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
    .mem_rdata(d_mem_rdata));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rw;
    logic        en;
    logic        mrw;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Each vector: inputs applied before an edge, outputs expected just after it.
    vecs[0]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h11111111, 4'b0000, 32'h0};
    vecs[1]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h100, 32'h11111111, 4'b0001, 32'hDEADBEEF};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h100, 32'h11111111, 4'b0000, 32'hDEADBEEF};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h110, 32'h22222222, 4'b0000, 32'hDEADBEEF};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h110, 32'h22222222, 4'b0010, 32'h5A5A0110};
    vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h120, 32'h33333333, 4'b0000, 32'h5A5A0110};
    vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h120, 32'h33333333, 4'b0100, 32'h5A5A0120};
    vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h130, 32'h44444444, 4'b0000, 32'h5A5A0120};
    vecs[8]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h130, 32'h44444444, 4'b1000, 32'h5A5A0130};
    vecs[9]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h11111111, 4'b0000, 32'h5A5A0130};
    vecs[10] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h100, 32'h11111111, 4'b0001, 32'hDEADBEEF};
    vecs[11] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h110, 32'h22222222, 4'b0000, 32'hDEADBEEF};
    vecs[12] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h110, 32'h22222222, 4'b0010, 32'h5A5A0110};
    vecs[13] = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 32'h120, 32'h33333333, 4'b0000, 32'h5A5A0110};
    vecs[14] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 32'h120, 32'h33333333, 4'b0100, 32'h5A5A0110};
    vecs[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h120, 32'h33333333, 4'b0000, 32'h5A5A0110};

    nreset = 1'b0;
    a_req = '0; a_rw = '0;
    b_req = '0; b_rw = '0;
    c_req = '0; c_rw = '0; c_addr = {32'h0, 32'h10};
    d_req = '0; d_rw = '0;

    #12;
    check("rst a ctl",   64'({a_ack, a_mem_en, a_mem_rw, a_mem_strb}), 64'h0);
    check("rst a addr",  64'(a_mem_addr),  64'h0);
    check("rst a wdata", 64'(a_mem_wdata), 64'h0);
    check("rst a rdata", 64'(a_rdata),     64'h0);
    check("rst b ctl",   64'({b_ack, b_mem_en, b_mem_rw, b_mem_strb}), 64'h0);
    check("rst b data",  64'({b_mem_addr, b_mem_wdata}), 64'h0);
    check("rst b rdata", 64'(b_rdata), 64'h0);
    check("rst c ctl",   64'({c_ack, c_mem_en, c_mem_rw, c_mem_strb}), 64'h0);
    check("rst c data",  64'({c_mem_addr, c_mem_wdata}), 64'h0);
    check("rst c rdata", 64'(c_rdata), 64'h0);
    check("rst d ctl",   64'({d_ack, d_mem_en, d_mem_rw, d_mem_strb}), 64'h0);
    check("rst d data",  64'({d_mem_addr, d_mem_wdata}), 64'h0);
    check("rst d rdata", 64'(d_rdata), 64'h0);

    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Single read, round-robin contention and a strobed write on instance A.
    for (int i = 0; i < 16; i++) begin
      a_req = vecs[i].req;
      a_rw  = vecs[i].rw;
      tick();
      check($sformatf("v%0d mem_en", i),    64'(a_mem_en),    64'(vecs[i].en));
      check($sformatf("v%0d mem_rw", i),    64'(a_mem_rw),    64'(vecs[i].mrw));
      check($sformatf("v%0d wstrobe", i),   64'(a_mem_strb),  64'(vecs[i].strb));
      check($sformatf("v%0d mem_addr", i),  64'(a_mem_addr),  64'(vecs[i].addr));
      check($sformatf("v%0d mem_wdata", i), 64'(a_mem_wdata), 64'(vecs[i].wdata));
      check($sformatf("v%0d ack", i),       64'(a_ack),       64'(vecs[i].ack));
      check($sformatf("v%0d rdata", i),     64'(a_rdata),     64'(vecs[i].rdata));
      @(negedge clk);
    end

    // Port1 write on B: mem_en for 4 cycles, then ack=10.
    b_req = 2'b10; b_rw = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("wr c%0d en", k),    64'(b_mem_en),    64'h1);
      check($sformatf("wr c%0d rw", k),    64'(b_mem_rw),    64'h1);
      check($sformatf("wr c%0d strb", k),  64'(b_mem_strb),  64'h3);
      check($sformatf("wr c%0d addr", k),  64'(b_mem_addr),  64'h200);
      check($sformatf("wr c%0d wdata", k), 64'(b_mem_wdata), 64'h12345678);
      check($sformatf("wr c%0d ack", k),   64'(b_ack),       64'h0);
    end
    tick();
    check("wr ack",    64'(b_ack),      64'h2);
    check("wr en off", 64'(b_mem_en),   64'h0);
    check("wr strb 0", 64'(b_mem_strb), 64'h0);
    check("wr rdata",  64'(b_rdata),    64'h0);
    @(negedge clk);
    b_req = '0; b_rw = '0;
    tick();
    check("wr ack 1cyc", 64'(b_ack), 64'h0);

    // Port0 read on C; addr changes and req drops right after grant.
    @(negedge clk);
    c_req = 2'b01;
    tick();
    check("chg grant en",   64'(c_mem_en),   64'h1);
    check("chg grant addr", 64'(c_mem_addr), 64'h10);
    @(negedge clk);
    c_addr = {32'h0, 32'h20};
    c_req  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("chg c%0d en", k),   64'(c_mem_en),   64'h1);
      check($sformatf("chg c%0d addr", k), 64'(c_mem_addr), 64'h10);
      check($sformatf("chg c%0d ack", k),  64'(c_ack),      64'h0);
    end
    tick();
    check("chg ack",   64'(c_ack),      64'h1);
    check("chg en",    64'(c_mem_en),   64'h0);
    check("chg addr",  64'(c_mem_addr), 64'h10);
    check("chg rdata", 64'(c_rdata),    64'h5A5A0010);

    // Port1 on D; reset lands in the second ACCESS cycle.
    @(negedge clk);
    d_req = 2'b10;
    tick();
    check("rm acc1 en",   64'(d_mem_en),   64'h1);
    check("rm acc1 addr", 64'(d_mem_addr), 64'h400);
    tick();
    check("rm acc2 en", 64'(d_mem_en), 64'h1);
    #2;
    nreset = 1'b0;
    #1;
    check("rm rst en",   64'(d_mem_en),   64'h0);
    check("rm rst ack",  64'(d_ack),      64'h0);
    check("rm rst addr", 64'(d_mem_addr), 64'h0);
    d_req = '0;
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rm no ack c%0d", k), 64'({d_ack, d_mem_en}), 64'h0);
    end
    @(negedge clk);
    d_req = 2'b11;
    tick();
    check("rm regrant en",   64'(d_mem_en),   64'h1);
    check("rm regrant addr", 64'(d_mem_addr), 64'h300);
    @(negedge clk);
    d_req = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
